bram_arbiter: RTL and testbench
===============================

BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 16, maximum ACCESS-state cycles to wait for mem_ready before aborting.
REQ-002 Reset rst, synchronous, active-high; clock clk.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 i_req  input  1  instruction-port read request, level, held until i_ack.
REQ-006 i_addr  input  32  instruction byte address.
REQ-007 i_rdata  output  32  instruction read data, registered.
REQ-008 i_ack  output  1  one-cycle completion pulse, instruction port.
REQ-009 d_req  input  1  data-port request, level, held until d_ack.
REQ-010 d_we  input  1  data-port write enable (1 = write).
REQ-011 d_addr  input  32  data byte address.
REQ-012 d_wdata  input  32  data write data.
REQ-013 d_bsel  input  4  data byte lanes.
REQ-014 d_rdata  output  32  data read data, registered.
REQ-015 d_ack  output  1  one-cycle completion pulse, data port.
REQ-016 mem_ce, mem_we  output  1 each  memory chip enable and write enable, registered.
REQ-017 mem_addr, mem_wdata  output  32 each; mem_bsel  output  4; registered memory command fields.
REQ-018 mem_rdata  input  32; mem_ready  input  1  one-cycle pulse, 2 clocks after mem_ce rising edge is sampled.
REQ-019 busy  output  1  high in any state other than IDLE.
REQ-020 timeout_err  output  1  sticky abort flag.

Function
REQ-021 FSM states IDLE, ACCESS, GAP; IDLE->ACCESS when i_req|d_req sampled high; ACCESS->GAP on mem_ready or timeout; GAP->IDLE unconditionally.
REQ-022 Arbitration in IDLE: single requester wins; both requesting -> port not granted last (round-robin); last_grant resets to instruction, so data wins first tie.
REQ-023 On IDLE->ACCESS edge, latch winner's command into mem_* registers: mem_ce=1; instruction grant -> mem_we=0, mem_bsel=0, mem_wdata=0; data grant -> mem_we=d_we, mem_bsel=d_we?d_bsel:0, mem_wdata=d_we?d_wdata:0.
REQ-024 mem_* fields held constant throughout ACCESS; requester inputs ignored after latch.
REQ-025 mem_ce is deasserted on ACCESS->GAP and stays 0 in GAP and IDLE, guaranteeing a fresh ce rising edge per access.
REQ-026 In the cycle mem_ready=1 in ACCESS: capture mem_rdata into the granted port's rdata register on reads only; writes leave rdata unchanged.
REQ-027 Granted port's ack is high for exactly the GAP cycle; other ack stays 0; acks never both high.
REQ-028 Latency: req high in cycle 0 -> mem_ce high cycle 1 -> mem_ready cycle 3 -> ack cycle 4 -> IDLE cycle 5; next mem_ce no earlier than cycle 6.
REQ-029 Requester drops req in the cycle after ack; IDLE in that cycle samples the already-dropped req.
REQ-030 Timeout counter: cleared on ACCESS entry, increments each ACCESS cycle without mem_ready; on reaching TIMEOUT-1 go to GAP, ack granted port, load rdata with 0 (reads), set timeout_err.
REQ-031 mem_ready arriving outside ACCESS is ignored.
REQ-032 mem_ready and timeout in same cycle: treat as normal completion, timeout_err unchanged.
REQ-033 last_grant updates on every IDLE->ACCESS transition.

Reset
REQ-034 On rst: state IDLE, mem_ce/mem_we=0, mem_addr/mem_wdata/mem_bsel=0, i_ack/d_ack=0, i_rdata/d_rdata=0, busy=0, timeout_err=0, counter=0, last_grant=instruction.
REQ-035 Reset mid-access aborts without ack; first post-reset request starts a fresh access.

Verification
REQ-036 Single read: i_req, i_addr=0x100, memory word 0xCAFE0001 -> mem_ce cycle 1, mem_addr=0x100, i_ack cycle 4, i_rdata=0xCAFE0001.
REQ-037 Write: d_we=1, d_addr=0x40, d_wdata=0x12345678, d_bsel=0x3 -> mem_we=1, mem_bsel=0x3, d_ack cycle 4, d_rdata unchanged.
REQ-038 Simultaneous i_req,d_req after reset -> data served first, instruction second; mem_ce low at least 2 cycles between accesses.
REQ-039 Continuous both requests for 4 accesses -> grants alternate D,I,D,I.
REQ-040 mem_ready suppressed -> ack after TIMEOUT ACCESS cycles, rdata=0, timeout_err=1 until rst.
REQ-041 rst asserted during ACCESS -> no ack, mem_ce=0 next cycle, all outputs at reset values.

Source files
------------

// File: rtl/bram_arbiter.sv
// Two-port (instruction / data) arbiter in front of a single block RAM.
// One access at a time: IDLE picks a winner and latches its command,
// ACCESS waits for the memory's ready pulse (or gives up after TIMEOUT
// cycles), and GAP acks the winner and forces mem_ce low for a cycle.
module bram_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_bsel,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_bsel,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        timeout_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic            r_lastGrantData;
  logic            r_grantData;
  logic [CW-1:0]   r_count;
  logic            w_anyReq;
  logic            w_pickData;
  logic            w_expired;

  // On a tie the port that did not win last time gets the memory.
  assign w_anyReq   = i_req | d_req;
  assign w_pickData = d_req & (~i_req | ~r_lastGrantData);
  assign w_expired  = (r_count == CW'(TIMEOUT - 1));
  assign busy       = (r_state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: a ready pulse wins over a simultaneous expiry.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_anyReq) w_nextState = ACCESS;
      ACCESS:  if (mem_ready || w_expired) w_nextState = GAP;
      GAP:     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Command latch, timeout counter, read-data capture and ack generation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lastGrantData <= 1'b0;
      r_grantData     <= 1'b0;
      r_count         <= '0;
      mem_ce          <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= 32'h0;
      mem_wdata       <= 32'h0;
      mem_bsel        <= 4'h0;
      i_ack           <= 1'b0;
      d_ack           <= 1'b0;
      i_rdata         <= 32'h0;
      d_rdata         <= 32'h0;
      timeout_err     <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_grantData     <= w_pickData;
            r_lastGrantData <= w_pickData;
            r_count         <= '0;
            mem_ce          <= 1'b1;
            if (w_pickData) begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_bsel  <= d_we ? d_bsel : 4'h0;
              mem_wdata <= d_we ? d_wdata : 32'h0;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= i_addr;
              mem_bsel  <= 4'h0;
              mem_wdata <= 32'h0;
            end
          end
        end
        ACCESS: begin
          if (mem_ready || w_expired) begin
            mem_ce <= 1'b0;
            if (r_grantData) begin
              d_ack <= 1'b1;
              if (!mem_we) d_rdata <= mem_ready ? mem_rdata : 32'h0;
            end else begin
              i_ack <= 1'b1;
              if (!mem_we) i_rdata <= mem_ready ? mem_rdata : 32'h0;
            end
            if (!mem_ready) timeout_err <= 1'b1;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: a behavioural memory answers each
// fresh mem_ce with a ready pulse, and a scoreboard of expected commands
// and completions is filled when requests are issued.
module tb_bram_arbiter;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_bsel;
  logic [31:0] i_rdata, d_rdata;
  logic        i_ack, d_ack;
  logic        mem_ce, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_bsel;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        busy, timeout_err;

  bram_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_bsel(d_bsel), .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_bsel(mem_bsel), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct {
    logic        isData;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  bsel;
    logic [31:0] wdata;
    int          ceCycle;
    int          ackCycle;
    logic [31:0] rdata;
    logic        tErr;
  } access_t;

  access_t     cmdQ[$];
  access_t     ackQ[$];
  int          cycleCount = 0;
  int          checkCount = 0;
  int          passCount  = 0;
  logic        memSuppress = 1'b0;
  int          memExtra = 0;
  logic        tbLastData = 1'b0;
  logic [31:0] tbIRdata = 32'h0;
  logic [31:0] tbDRdata = 32'h0;
  logic        tbTErr = 1'b0;

  initial forever #5 clk = ~clk;

  // Cycle index: cycle N lies between the Nth and (N+1)th rising edge.
  initial forever begin
    @(posedge clk);
    cycleCount++;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h100) return 32'hCAFE0001;
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
  endtask

  // Memory stand-in: ready two clocks after a fresh mem_ce is sampled.
  initial begin
    logic        prevCe;
    logic        wasWrite;
    logic [31:0] rdAddr;
    prevCe    = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_ce && !prevCe && !memSuppress) begin
        wasWrite = mem_we;
        rdAddr   = mem_addr;
        repeat (2 + memExtra) @(posedge clk);
        #1;
        mem_ready = 1'b1;
        mem_rdata = wasWrite ? 32'hBAD0BAD0 : memWord(rdAddr);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
      end
      prevCe = mem_ce;
    end
  end

  // Scoreboard consumer: command at each mem_ce rise, result at each ack.
  initial begin
    logic    prevCe;
    access_t e;
    prevCe = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_ce && !prevCe) begin
        if (cmdQ.size() == 0) begin
          checkOutput("spuriousCe", 64'(1), 64'(0));
        end else begin
          e = cmdQ.pop_front();
          checkOutput("ceCycle", 64'(cycleCount), 64'(e.ceCycle));
          checkOutput("memAddr", 64'(mem_addr), 64'(e.addr));
          checkOutput("memWe", 64'(mem_we), 64'(e.we));
          checkOutput("memBsel", 64'(mem_bsel), 64'(e.we ? e.bsel : 4'h0));
          checkOutput("memWdata", 64'(mem_wdata), 64'(e.we ? e.wdata : 32'h0));
        end
      end
      prevCe = mem_ce;
      if (i_ack || d_ack) begin
        if (ackQ.size() == 0) begin
          checkOutput("spuriousAck", 64'(1), 64'(0));
        end else begin
          e = ackQ.pop_front();
          checkOutput("ackCycle", 64'(cycleCount), 64'(e.ackCycle));
          checkOutput("ackPort", 64'({i_ack, d_ack}), 64'(e.isData ? 2'b01 : 2'b10));
          checkOutput("rdata", 64'(e.isData ? d_rdata : i_rdata), 64'(e.rdata));
          checkOutput("timeoutErr", 64'(timeout_err), 64'(e.tErr));
          checkOutput("memAddrHeld", 64'(mem_addr), 64'(e.addr));
          checkOutput("gapState", 64'({busy, mem_ce}), 64'(2'b10));
        end
      end
    end
  end

  // Issue requests on one or both ports, queue the expected outcome and
  // run the level handshake until every raised request has been acked.
  task automatic applyStimulus(input logic doI, input logic [31:0] iA,
                               input logic doD, input logic dW,
                               input logic [31:0] dA, input logic [31:0] dWd,
                               input logic [3:0] dB);
    access_t order[$];
    access_t eI, eD, e;
    int      start, accessCycles, nextCe, guard;
    logic    timedOut, iDone, dDone, iDrop, dDrop;
    timedOut     = memSuppress || (3 + memExtra > TIMEOUT);
    accessCycles = timedOut ? TIMEOUT : 3 + memExtra;
    eI = '{isData: 1'b0, addr: iA, we: 1'b0, bsel: 4'h0, wdata: 32'h0,
           ceCycle: 0, ackCycle: 0, rdata: 32'h0, tErr: 1'b0};
    eD = '{isData: 1'b1, addr: dA, we: dW, bsel: dB, wdata: dWd,
           ceCycle: 0, ackCycle: 0, rdata: 32'h0, tErr: 1'b0};
    if (doD && (!doI || !tbLastData)) begin
      order.push_back(eD);
      if (doI) order.push_back(eI);
    end else begin
      if (doI) order.push_back(eI);
      if (doD) order.push_back(eD);
    end
    start  = cycleCount;
    nextCe = start + 1;
    foreach (order[k]) begin
      e          = order[k];
      e.ceCycle  = nextCe;
      e.ackCycle = nextCe + accessCycles;
      nextCe     = e.ackCycle + 2;
      if (e.we)          e.rdata = tbDRdata;
      else if (timedOut) e.rdata = 32'h0;
      else               e.rdata = memWord(e.addr);
      if (e.isData) tbDRdata = e.rdata;
      else          tbIRdata = e.rdata;
      tbTErr     = tbTErr | timedOut;
      e.tErr     = tbTErr;
      tbLastData = e.isData;
      cmdQ.push_back(e);
      ackQ.push_back(e);
    end
    i_req = doI; i_addr = iA;
    d_req = doD; d_we = dW; d_addr = dA; d_wdata = dWd; d_bsel = dB;
    iDone = !doI; dDone = !doD; iDrop = 1'b0; dDrop = 1'b0; guard = 0;
    while (!(iDone && dDone) && guard < 400) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard == 1 && (doI != doD)) begin
        i_addr = ~iA; d_addr = ~dA; d_wdata = ~dWd; d_bsel = ~dB;
      end
      if (iDrop) begin i_req = 1'b0; iDrop = 1'b0; end
      if (dDrop) begin d_req = 1'b0; dDrop = 1'b0; end
      if (!iDone && i_ack) begin iDone = 1'b1; iDrop = 1'b1; end
      if (!dDone && d_ack) begin dDone = 1'b1; dDrop = 1'b1; end
    end
    if (!(iDone && dDone)) checkOutput("ackWait", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    if (iDrop) i_req = 1'b0;
    if (dDrop) d_req = 1'b0;
  endtask

  task automatic resetModel();
    tbLastData = 1'b0;
    tbIRdata   = 32'h0;
    tbDRdata   = 32'h0;
    tbTErr     = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "Mem"}, 64'({mem_ce, mem_we, mem_bsel}), 64'(0));
    checkOutput({tag, "MemAddr"}, 64'({mem_addr, mem_wdata}), 64'(0));
    checkOutput({tag, "Acks"}, 64'({i_ack, d_ack, busy, timeout_err}), 64'(0));
    checkOutput({tag, "Rdata"}, 64'({i_rdata, d_rdata}), 64'(0));
  endtask

  // Main sequence.
  initial begin
    int start;
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_bsel = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst = 1'b0;
    resetModel();
    @(posedge clk);
    #1;

    $display("[TB] tie after reset: data first");
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
    $display("[TB] data write keeps d_rdata");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h12345678, 4'h3);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0, 4'hF);
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    $display("[TB] continuous requests alternate");
    applyStimulus(1'b1, 32'h104, 1'b1, 1'b1, 32'h44, 32'hA5A5A5A5, 4'hC);
    applyStimulus(1'b1, 32'h108, 1'b1, 1'b0, 32'h48, 32'h0, 4'h0);

    $display("[TB] ready on the last allowed cycle");
    memExtra = TIMEOUT - 3;
    applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    memExtra = 0;

    $display("[TB] suppressed ready times out");
    memSuppress = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h600, 32'h0, 4'h0);
    memSuppress = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("stickyErr", 64'(timeout_err), 64'(1));
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    $display("[TB] reset during access");
    start = cycleCount;
    i_req = 1'b1; i_addr = 32'h700;
    cmdQ.push_back('{isData: 1'b0, addr: 32'h700, we: 1'b0, bsel: 4'h0,
                     wdata: 32'h0, ceCycle: start + 1, ackCycle: 0,
                     rdata: 32'h0, tErr: 1'b0});
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("midAccessBusy", 64'({busy, mem_ce}), 64'(2'b11));
    rst = 1'b1; i_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    resetModel();
    checkResetValues("midReset");
    @(posedge clk);
    #1;
    checkResetValues("lateReady");

    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    applyStimulus(1'b1, 32'h110, 1'b1, 1'b0, 32'h310, 32'h0, 4'h0);

    repeat (4) @(posedge clk);
    #1;
    checkOutput("cmdQEmpty", 64'(cmdQ.size()), 64'(0));
    checkOutput("ackQEmpty", 64'(ackQ.size()), 64'(0));
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
